// File: rtl/cpu_pkg.sv
// Shared CPU constants and the operand-fetch FSM state type.
package cpu_pkg;

    localparam int REG_W = 64;
    localparam int SEL_W = 6;
    localparam int OPC_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        HOLD
    } opf_state_t;

endpackage

// File: rtl/opfetch_if.sv
// Operand-fetch bundle: request in, regbank read port, write-back snoop, operands out.
interface opfetch_if;
    import cpu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [SEL_W-1:0] req_sel_a;
    logic [SEL_W-1:0] req_sel_b;
    logic             req_nb;
    logic [OPC_W-1:0] req_opcode;

    logic             rd_en;
    logic [SEL_W-1:0] rd_sel;
    logic [REG_W-1:0] rd_val;

    logic             wb_we;
    logic [SEL_W-1:0] wb_sel;
    logic [REG_W-1:0] wb_val;

    logic             op_valid;
    logic             op_ready;
    logic [REG_W-1:0] op_a;
    logic [REG_W-1:0] op_b;
    logic [OPC_W-1:0] op_opcode;

    modport slave (
        input  req_valid, req_sel_a, req_sel_b, req_nb, req_opcode,
        input  rd_val, wb_we, wb_sel, wb_val, op_ready,
        output req_ready, rd_en, rd_sel, op_valid, op_a, op_b, op_opcode
    );

    modport master (
        output req_valid, req_sel_a, req_sel_b, req_nb, req_opcode,
        output rd_val, wb_we, wb_sel, wb_val, op_ready,
        input  req_ready, rd_en, rd_sel, op_valid, op_a, op_b, op_opcode
    );

endinterface

// File: rtl/opf_slot.sv
// One operand slot: captures read data and overrides it with snooped write-backs
// from the read issue cycle onward.
module opf_slot
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             cap,
    input  logic             clr,
    input  logic [SEL_W-1:0] sel_in,
    input  logic [REG_W-1:0] rd_val,
    input  logic             wb_we,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic [REG_W-1:0] wb_val,
    output logic [REG_W-1:0] val
);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] cmp_sel;
    logic             live;
    logic             pend;
    logic             hit;

    assign cmp_sel = arm ? sel_in : sel_q;
    assign hit     = wb_we && (wb_sel == cmp_sel);

    // A hit in the issue cycle is missed by the read port, so it is parked in val
    // and pend stops the following capture from overwriting it with stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val   <= '0;
            sel_q <= '0;
            live  <= 1'b0;
            pend  <= 1'b0;
        end else if (clr) begin
            val  <= '0;
            live <= 1'b0;
            pend <= 1'b0;
        end else if (arm) begin
            sel_q <= sel_in;
            live  <= 1'b0;
            pend  <= hit;
            if (hit) val <= wb_val;
        end else if (cap) begin
            live <= 1'b1;
            if (hit)       val <= wb_val;
            else if (!pend) val <= rd_val;
        end else if (live && hit) begin
            val <= wb_val;
        end
    end

endmodule

// File: rtl/opfetch.sv
// Operand fetch: sequences two reads over the single regbank port and holds
// forwarded operands for the ALU until accepted.
module opfetch
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    opfetch_if.slave bus
);

    opf_state_t       state;
    opf_state_t       state_nxt;
    logic [SEL_W-1:0] sel_a_q;
    logic [SEL_W-1:0] sel_b_q;
    logic             nb_q;
    logic [OPC_W-1:0] opc_q;
    logic             accept;

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = RD_A;
            RD_A:    state_nxt = RD_B;
            RD_B:    state_nxt = nb_q ? HOLD : CAP_B;
            CAP_B:   state_nxt = HOLD;
            HOLD:    if (bus.op_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read strobe/select and op_valid come from registered state only.
    always_comb begin
        bus.req_ready = (state == IDLE) && !reset;
        bus.rd_en     = 1'b0;
        bus.rd_sel    = '0;
        bus.op_valid  = (state == HOLD);
        if (state == RD_A) begin
            bus.rd_en  = 1'b1;
            bus.rd_sel = sel_a_q;
        end else if (state == RD_B && !nb_q) begin
            bus.rd_en  = 1'b1;
            bus.rd_sel = sel_b_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_a_q <= '0;
            sel_b_q <= '0;
            nb_q    <= 1'b0;
            opc_q   <= '0;
        end else if (accept) begin
            sel_a_q <= bus.req_sel_a;
            sel_b_q <= bus.req_sel_b;
            nb_q    <= bus.req_nb;
            opc_q   <= bus.req_opcode;
        end
    end

    assign bus.op_opcode = opc_q;

    opf_slot u_slot_a (
        .clk    (clk),
        .reset  (reset),
        .arm    (state == RD_A),
        .cap    (state == RD_B),
        .clr    (accept),
        .sel_in (sel_a_q),
        .rd_val (bus.rd_val),
        .wb_we  (bus.wb_we),
        .wb_sel (bus.wb_sel),
        .wb_val (bus.wb_val),
        .val    (bus.op_a)
    );

    // With nb set, slot B is cleared on accept and never armed, so it stays 0.
    opf_slot u_slot_b (
        .clk    (clk),
        .reset  (reset),
        .arm    (state == RD_B && !nb_q),
        .cap    (state == CAP_B),
        .clr    (accept),
        .sel_in (sel_b_q),
        .rd_val (bus.rd_val),
        .wb_we  (bus.wb_we),
        .wb_sel (bus.wb_sel),
        .wb_val (bus.wb_val),
        .val    (bus.op_b)
    );

endmodule

// File: tb/tb_opfetch.sv
// Bench for opfetch: regbank model, request/latency scoreboard and directed scenarios.
module tb_opfetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    opfetch_if bus();

    opfetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [REG_W-1:0] mem [0:63];

    // Synchronous regbank: a read sees contents from before a same-edge write.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_val <= mem[bus.rd_sel];
        if (bus.wb_we) mem[bus.wb_sel] <= bus.wb_val;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard of the outstanding request.
    logic             have_req = 1'b0;
    int               acc = 0;
    int               due = 0;
    logic [SEL_W-1:0] m_sa = '0;
    logic [SEL_W-1:0] m_sb = '0;
    logic             m_nb = 1'b0;
    logic [OPC_W-1:0] m_opc = '0;

    always @(posedge clk) begin
        if (reset) begin
            have_req <= 1'b0;
        end else begin
            if (have_req && cyc >= due && bus.op_ready) have_req <= 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                have_req <= 1'b1;
                acc      <= cyc;
                due      <= cyc + (bus.req_nb ? 3 : 4);
                m_sa     <= bus.req_sel_a;
                m_sb     <= bus.req_sel_b;
                m_nb     <= bus.req_nb;
                m_opc    <= bus.req_opcode;
            end
        end
        cyc <= cyc + 1;
    end

    // Operands must equal the current register contents while valid.
    logic exp_vld;
    logic exp_rd;
    always @(negedge clk) begin
        if (!reset) begin
            exp_vld = have_req && (cyc >= due);
            exp_rd  = have_req && ((cyc == acc + 1) || (cyc == acc + 2 && !m_nb));
            chk("op_valid", 64'(bus.op_valid), 64'(exp_vld));
            chk("req_ready", 64'(bus.req_ready), 64'(!have_req));
            chk("rd_en", 64'(bus.rd_en), 64'(exp_rd));
            if (exp_rd)
                chk("rd_sel", 64'(bus.rd_sel), 64'((cyc == acc + 1) ? m_sa : m_sb));
            if (exp_vld) begin
                chk("op_a", bus.op_a, mem[m_sa]);
                chk("op_b", bus.op_b, m_nb ? 64'h0 : mem[m_sb]);
                chk("op_opcode", 64'(bus.op_opcode), 64'(m_opc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) tick();
    endtask

    task automatic wr(input logic [SEL_W-1:0] s, input logic [REG_W-1:0] v);
        bus.wb_we  = 1'b1;
        bus.wb_sel = s;
        bus.wb_val = v;
        tick();
        bus.wb_we  = 1'b0;
    endtask

    task automatic send(input logic [SEL_W-1:0] a, input logic [SEL_W-1:0] b,
                        input logic nb, input logic [OPC_W-1:0] opc, output int t);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_sel_a  = a;
        bus.req_sel_b  = b;
        bus.req_nb     = nb;
        bus.req_opcode = opc;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_accept", 64'(bus.req_ready), 64'h1);
        t = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic run_two();
        int t;
        wr(6'd3, 64'h11);
        wr(6'd7, 64'h22);
        send(6'd3, 6'd7, 1'b0, 8'h5A, t);
        wait_cyc(t + 1);
        chk("s1_rd_en_t1", 64'(bus.rd_en), 64'h1);
        chk("s1_rd_sel_t1", 64'(bus.rd_sel), 64'd3);
        wait_cyc(t + 2);
        chk("s1_rd_sel_t2", 64'(bus.rd_sel), 64'd7);
        wait_cyc(t + 3);
        chk("s1_valid_t3", 64'(bus.op_valid), 64'h0);
        wait_cyc(t + 4);
        chk("s1_valid_t4", 64'(bus.op_valid), 64'h1);
        chk("s1_op_a", bus.op_a, 64'h11);
        chk("s1_op_b", bus.op_b, 64'h22);
        chk("s1_opcode", 64'(bus.op_opcode), 64'h5A);
        wait_cyc(t + 5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.req_valid  = 1'b0;
        bus.req_sel_a  = '0;
        bus.req_sel_b  = '0;
        bus.req_nb     = 1'b0;
        bus.req_opcode = '0;
        bus.wb_we      = 1'b0;
        bus.wb_sel     = '0;
        bus.wb_val     = '0;
        bus.op_ready   = 1'b1;
        reset          = 1'b1;

        tick();
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
        chk("rst_op_valid", 64'(bus.op_valid), 64'h0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'h0);
        chk("rst_rd_sel", 64'(bus.rd_sel), 64'h0);
        chk("rst_op_a", bus.op_a, 64'h0);
        chk("rst_op_b", bus.op_b, 64'h0);
        chk("rst_opcode", 64'(bus.op_opcode), 64'h0);
        reset = 1'b0;
        tick();
        chk("rst_release_ready", 64'(bus.req_ready), 64'h1);

        run_two();

        // Single operand
        wr(6'd9, 64'hABCD);
        send(6'd9, 6'd0, 1'b1, 8'h3C, t);
        wait_cyc(t + 1);
        chk("s2_rd_en_t1", 64'(bus.rd_en), 64'h1);
        wait_cyc(t + 2);
        chk("s2_rd_en_t2", 64'(bus.rd_en), 64'h0);
        wait_cyc(t + 3);
        chk("s2_valid_t3", 64'(bus.op_valid), 64'h1);
        chk("s2_op_a", bus.op_a, 64'hABCD);
        chk("s2_op_b", bus.op_b, 64'h0);
        wait_cyc(t + 4);

        // Forward in RD_A
        wr(6'd3, 64'h11);
        wr(6'd4, 64'h44);
        send(6'd3, 6'd4, 1'b0, 8'h01, t);
        wait_cyc(t + 1);
        wr(6'd3, 64'h99);
        wait_cyc(t + 4);
        chk("fa_op_a", bus.op_a, 64'h99);
        chk("fa_op_b", bus.op_b, 64'h44);
        wait_cyc(t + 5);

        // Forward in RD_B
        wr(6'd3, 64'h11);
        send(6'd3, 6'd4, 1'b0, 8'h02, t);
        wait_cyc(t + 2);
        wr(6'd3, 64'h99);
        wait_cyc(t + 4);
        chk("fb_op_a", bus.op_a, 64'h99);
        wait_cyc(t + 5);

        // Forward during HOLD
        wr(6'd3, 64'h11);
        bus.op_ready = 1'b0;
        send(6'd3, 6'd4, 1'b0, 8'h03, t);
        wait_cyc(t + 4);
        chk("fh_op_a_before", bus.op_a, 64'h11);
        wr(6'd3, 64'h99);
        chk("fh_op_a_after", bus.op_a, 64'h99);
        bus.op_ready = 1'b1;
        wait_cyc(t + 6);

        // Aliased selects, write during CAP_B
        wr(6'd5, 64'h1);
        send(6'd5, 6'd5, 1'b0, 8'h77, t);
        wait_cyc(t + 3);
        wr(6'd5, 64'h7);
        chk("al_op_a", bus.op_a, 64'h7);
        chk("al_op_b", bus.op_b, 64'h7);
        wait_cyc(t + 5);

        // Backpressure
        wr(6'd1, 64'h1111);
        wr(6'd2, 64'h2222);
        bus.op_ready = 1'b0;
        send(6'd1, 6'd2, 1'b0, 8'h42, t);
        wait_cyc(t + 4);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(bus.op_valid), 64'h1);
            chk("bp_op_a", bus.op_a, 64'h1111);
            chk("bp_op_b", bus.op_b, 64'h2222);
            chk("bp_opcode", 64'(bus.op_opcode), 64'h42);
            chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
            chk("bp_rd_en", 64'(bus.rd_en), 64'h0);
            if (i == 9) bus.op_ready = 1'b1;
            tick();
        end
        chk("bp_release_valid", 64'(bus.op_valid), 64'h0);
        chk("bp_release_ready", 64'(bus.req_ready), 64'h1);
        run_two();

        // Asynchronous reset during CAP_B
        wr(6'd3, 64'h11);
        wr(6'd7, 64'h22);
        send(6'd3, 6'd7, 1'b0, 8'h5A, t);
        wait_cyc(t + 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_op_valid", 64'(bus.op_valid), 64'h0);
        chk("ar_rd_en", 64'(bus.rd_en), 64'h0);
        chk("ar_rd_sel", 64'(bus.rd_sel), 64'h0);
        chk("ar_op_a", bus.op_a, 64'h0);
        chk("ar_op_b", bus.op_b, 64'h0);
        chk("ar_opcode", 64'(bus.op_opcode), 64'h0);
        chk("ar_req_ready", 64'(bus.req_ready), 64'h0);
        tick();
        chk("ar_hold_valid", 64'(bus.op_valid), 64'h0);
        reset = 1'b0;
        tick();
        chk("ar_after_ready", 64'(bus.req_ready), 64'h1);
        chk("ar_after_valid", 64'(bus.op_valid), 64'h0);
        run_two();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
